// File: rtl/call_stack_pkg.sv
// Shared constants and types for the hardware return-address stack and the
// datapath blocks that must agree with it (IP register width, src_a mux code).
package call_stack_pkg;

  localparam int CSTK_DEPTH = 16;
  localparam int ADDR_W     = 16;

  // src_a operand select code for the call-stack top
  localparam logic [1:0] SRC_CSTK = 2'h3;

  // Decoder request, encoded as {cpush, cpop}
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } cstk_op_e;

endpackage

// File: rtl/call_stack_if.sv
// Decoder/status-facing signal bundle of the call stack; master is the
// decoder/datapath side, slave is the stack itself.
interface call_stack_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) ();

  logic                       cpush;
  logic                       cpop;
  logic [WIDTH-1:0]           push_data;
  logic                       err_clr;
  logic [WIDTH-1:0]           top;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output cpush, cpop, push_data, err_clr,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  cpush, cpop, push_data, err_clr,
    output top, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/call_stack_mem.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read.
// Kept separate so the storage can later map onto distributed RAM.
module call_stack_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Return-address stack driven by decoder cpush/cpop; top is readable in the
// same cycle as the pop that discards it. Saturates and flags errors instead of wrapping.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH = CSTK_DEPTH,
  parameter int WIDTH = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  call_stack_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             empty, full;
  logic             ovf_set, unf_set;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] rdata;
  cstk_op_e         op;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign top_idx = AW'(count_q - CW'(1));
  assign op      = cstk_op_e'({bus.cpush, bus.cpop});

  always_comb begin
    count_d = count_q;
    we      = 1'b0;
    waddr   = count_q[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      OP_REPL: begin
        // Replace in place; on an empty stack this degenerates to a plain push
        we = 1'b1;
        if (empty) begin
          count_d = CW'(1);
        end else begin
          waddr = top_idx;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Error set takes priority over a simultaneous clear
  assign overflow_d  = ovf_set | (overflow_q  & ~bus.err_clr);
  assign underflow_d = unf_set | (underflow_q & ~bus.err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  call_stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (we & rst_n),
    .waddr_i (waddr),
    .wdata_i (bus.push_data),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  assign bus.top       = empty ? '0 : rdata;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: table of single-cycle vectors plus
// hand-written sequences for fill/overflow and asynchronous reset.
module tb_call_stack;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  call_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        cpush;
    logic        cpop;
    logic [15:0] data;
    logic        clr;
    logic [4:0]  cnt;
    logic [15:0] top;
    logic        e;
    logic        f;
    logic        o;
    logic        u;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] cnt, input logic [15:0] top,
                         input logic e, input logic f, input logic o, input logic u);
    chk({tag, ".count"},     32'(bus.count),     32'(cnt));
    chk({tag, ".top"},       32'(bus.top),       32'(top));
    chk({tag, ".empty"},     32'(bus.empty),     32'(e));
    chk({tag, ".full"},      32'(bus.full),      32'(f));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(o));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(u));
  endtask

  task automatic drive(input logic p, input logic q, input logic [15:0] d, input logic c);
    bus.cpush     = p;
    bus.cpop      = q;
    bus.push_data = d;
    bus.err_clr   = c;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0000, 1'b0);

    //           push  pop   data     clr   cnt    top      e     f     o     u
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0102, 1'b0, 5'd1, 16'h0102, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0FF2, 1'b0, 5'd2, 16'h0FF2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 5'd1, 16'h0102, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 5'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 5'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h0200, 1'b0, 5'd2, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0300, 1'b0, 5'd3, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'h0AAA, 1'b0, 5'd3, 16'h0AAA, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'h0000, 1'b0, 5'd2, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h0000, 1'b0, 5'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h0000, 1'b1, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 16'h0000, 1'b1, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) cycle();
    chk_all("reset", 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: top must show the entry being popped before the popping edge
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].cpush, vecs[i].cpop, vecs[i].data, vecs[i].clr);
      if (i == 11) chk("v11.pre_pop_top", 32'(bus.top), 32'h0AAA);
      cycle();
      chk_all($sformatf("v%0d", i), vecs[i].cnt, vecs[i].top,
              vecs[i].e, vecs[i].f, vecs[i].o, vecs[i].u);
    end

    // Fill to DEPTH, then push once more while full
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 16'(16'h1000 + 2 * i), 1'b0);
      cycle();
    end
    chk_all("fill16", 5'd16, 16'h101E, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'hBEEF, 1'b0);
    cycle();
    chk_all("push17", 5'd16, 16'h101E, 1'b0, 1'b1, 1'b1, 1'b0);

    // Clear coincident with another overflow: set wins
    @(negedge clk);
    drive(1'b1, 1'b0, 16'hBEEF, 1'b1);
    cycle();
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);

    // No write and no combinational path from push_data when idle
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h7777, 1'b1);
    #1;
    chk("no_comb_path", 32'(bus.top), 32'h101E);
    cycle();
    chk_all("err_clr", 5'd16, 16'h101E, 1'b0, 1'b1, 1'b0, 1'b0);

    // Replace while full keeps count
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h5A5A, 1'b0);
    cycle();
    chk_all("repl_full", 5'd16, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000, 1'b0);
    cycle();
    chk_all("pop_after_repl", 5'd15, 16'h101C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with count=5
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 16'(16'h0500 + i), 1'b0);
      cycle();
    end
    chk_all("count5", 5'd5, 16'h0504, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.count", 32'(bus.count), 32'd0);
    chk("async_rst.top",   32'(bus.top),   32'h0000);
    chk("async_rst.empty", 32'(bus.empty), 32'd1);

    // Push while reset still low at the edge is lost
    drive(1'b1, 1'b0, 16'h0055, 1'b0);
    cycle();
    chk("push_in_reset", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk_all("push_after_rel", 5'd1, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
